// File: rtl/conv_rag_pkg.sv
// Shared types and helpers for the convolution read address generator.
package conv_rag_pkg;

  typedef enum logic [1:0] {
    RAG_IDLE     = 2'd0,
    RAG_RUN      = 2'd1,
    RAG_ROW_WAIT = 2'd2
  } rag_state_e;

  // Runtime sizes of zero are treated as one.
  function automatic int unsigned clamp_one(input int unsigned v);
    return (v == 0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/conv_rag_tap_counter.sv
// Nested channel/tap counter: ch is innermost (0..c-1), then tap (0..k-1).
// Exposes the next-cycle counter values so the parent can register the
// address that belongs to them.
module conv_rag_tap_counter
  import conv_rag_pkg::*;
#(
  parameter int unsigned FILT_W = 8,
  parameter int unsigned CH_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [FILT_W-1:0] k,
  input  logic [CH_W-1:0]   c,
  output logic [FILT_W-1:0] tap,
  output logic [CH_W-1:0]   ch,
  output logic [FILT_W-1:0] tap_nxt_c,
  output logic [CH_W-1:0]   ch_nxt_c,
  output logic              last_c
);

  // Last element of the window: final tap of the final channel.
  always_comb begin
    last_c = (tap == (k - FILT_W'(1))) && (ch == (c - CH_W'(1)));
  end

  // Next counter values: clear wins over advance.
  always_comb begin
    tap_nxt_c = tap;
    ch_nxt_c  = ch;
    if (clr) begin
      tap_nxt_c = '0;
      ch_nxt_c  = '0;
    end else if (en) begin
      if (ch == (c - CH_W'(1))) begin
        ch_nxt_c = '0;
        if (tap == (k - FILT_W'(1))) begin
          tap_nxt_c = '0;
        end else begin
          tap_nxt_c = tap + FILT_W'(1);
        end
      end else begin
        ch_nxt_c = ch + CH_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap <= '0;
      ch  <= '0;
    end else begin
      tap <= tap_nxt_c;
      ch  <= ch_nxt_c;
    end
  end

endmodule

// File: rtl/conv_read_addr_gen.sv
// Sliding-window read address generator over an interleaved multi-channel
// row in a circular input-feature buffer.
// read_addr = offset + tap*D*C + ch (mod 2**ADDR_W), ch innermost.
// Optional feature macro: CONV_RAG_DILATION_EN adds the dilation port and
// tap spacing D; without it D is fixed at 1.
module conv_read_addr_gen
  import conv_rag_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned FILT_W   = 8,
  parameter int unsigned STRIDE_W = 3,
  parameter int unsigned CH_W     = 4
`ifdef CONV_RAG_DILATION_EN
  ,
  parameter int unsigned DIL_W    = 3
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   row_base,
  input  logic [FILT_W-1:0]   filter_size,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [CH_W-1:0]     num_ch,
`ifdef CONV_RAG_DILATION_EN
  input  logic [DIL_W-1:0]    dilation,
`endif
  input  logic                end_of_row,
  input  logic                next_row,
  input  logic                addr_ready,
  output logic                addr_valid,
  output logic [ADDR_W-1:0]   read_addr,
  output logic                window_done,
  output logic                row_wait
);

  localparam logic [1:0] ST_IDLE     = RAG_IDLE;
  localparam logic [1:0] ST_RUN      = RAG_RUN;
  localparam logic [1:0] ST_ROW_WAIT = RAG_ROW_WAIT;

  logic [1:0]          state,  state_nxt;
  logic [ADDR_W-1:0]   offset, offset_nxt;
  logic [FILT_W-1:0]   k_r,    k_nxt;
  logic [STRIDE_W-1:0] s_r,    s_nxt;
  logic [CH_W-1:0]     c_r,    c_nxt;
`ifdef CONV_RAG_DILATION_EN
  logic [DIL_W-1:0]    d_r,    d_nxt;
`endif
  logic                cnt_en, cnt_clr, done_nxt;
  logic [FILT_W-1:0]   tap,    tap_nxt;
  logic [CH_W-1:0]     ch,     ch_nxt;
  logic                last;
  logic                accept;
  logic [ADDR_W-1:0]   addr_nxt;

  assign accept = addr_valid & addr_ready;

  conv_rag_tap_counter #(
    .FILT_W (FILT_W),
    .CH_W   (CH_W)
  ) u_tap_counter (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .k         (k_r),
    .c         (c_r),
    .tap       (tap),
    .ch        (ch),
    .tap_nxt_c (tap_nxt),
    .ch_nxt_c  (ch_nxt),
    .last_c    (last)
  );

  // Next state, config latch and counter control; priority stop > start > next_row > accept.
  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    k_nxt      = k_r;
    s_nxt      = s_r;
    c_nxt      = c_r;
`ifdef CONV_RAG_DILATION_EN
    d_nxt      = d_r;
`endif
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    done_nxt   = 1'b0;
    if (stop) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
    end else if (start) begin
      state_nxt  = ST_RUN;
      offset_nxt = row_base;
      k_nxt      = FILT_W'(clamp_one(32'(filter_size)));
      s_nxt      = STRIDE_W'(clamp_one(32'(stride)));
      c_nxt      = CH_W'(clamp_one(32'(num_ch)));
`ifdef CONV_RAG_DILATION_EN
      d_nxt      = DIL_W'(clamp_one(32'(dilation)));
`endif
      cnt_clr    = 1'b1;
    end else if (next_row && (state != ST_IDLE)) begin
      state_nxt  = ST_RUN;
      offset_nxt = row_base;
      cnt_clr    = 1'b1;
    end else if ((state == ST_RUN) && accept) begin
      cnt_en = 1'b1;
      if (last) begin
        done_nxt = 1'b1;
        if (end_of_row) begin
          state_nxt = ST_ROW_WAIT;
        end else begin
          offset_nxt = ADDR_W'(32'(offset) + 32'(s_r) * 32'(c_r));
        end
      end
    end
  end

  // Address of the element the counters will point at next cycle.
`ifdef CONV_RAG_DILATION_EN
  assign addr_nxt = ADDR_W'(32'(offset_nxt) + 32'(tap_nxt) * 32'(d_nxt) * 32'(c_nxt)
                            + 32'(ch_nxt));
`else
  assign addr_nxt = ADDR_W'(32'(offset_nxt) + 32'(tap_nxt) * 32'(c_nxt) + 32'(ch_nxt));
`endif

  // State, config and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      offset      <= '0;
      k_r         <= FILT_W'(1);
      s_r         <= STRIDE_W'(1);
      c_r         <= CH_W'(1);
`ifdef CONV_RAG_DILATION_EN
      d_r         <= DIL_W'(1);
`endif
      addr_valid  <= 1'b0;
      read_addr   <= '0;
      window_done <= 1'b0;
      row_wait    <= 1'b0;
    end else begin
      state       <= state_nxt;
      offset      <= offset_nxt;
      k_r         <= k_nxt;
      s_r         <= s_nxt;
      c_r         <= c_nxt;
`ifdef CONV_RAG_DILATION_EN
      d_r         <= d_nxt;
`endif
      addr_valid  <= (state_nxt == ST_RUN);
      read_addr   <= addr_nxt;
      window_done <= done_nxt;
      row_wait    <= (state_nxt == ST_ROW_WAIT);
    end
  end

endmodule
